// File: rtl/game_pkg.sv
// Shared game constants: command codes, PS/2 scancodes, repeat FSM states, key-to-command map.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package game_pkg;

    localparam logic [3:0] CMD_NONE  = 4'd0;
    localparam logic [3:0] CMD_UP    = 4'd1;
    localparam logic [3:0] CMD_LEFT  = 4'd2;
    localparam logic [3:0] CMD_DOWN  = 4'd3;
    localparam logic [3:0] CMD_RIGHT = 4'd4;
    localparam logic [3:0] CMD_NEXT  = 4'd5;
    localparam logic [3:0] CMD_BACK  = 4'd6;
    localparam logic [3:0] CMD_RETRY = 4'd7;
    localparam logic [3:0] CMD_SEL1  = 4'd8;
    localparam logic [3:0] CMD_SEL2  = 4'd9;
    localparam logic [3:0] CMD_SEL3  = 4'd10;

    localparam logic [8:0] SC_UP     = 9'h01D;
    localparam logic [8:0] SC_LEFT   = 9'h01C;
    localparam logic [8:0] SC_DOWN   = 9'h01B;
    localparam logic [8:0] SC_RIGHT  = 9'h023;
    localparam logic [8:0] SC_NEXT   = 9'h031;
    localparam logic [8:0] SC_BACK   = 9'h032;
    localparam logic [8:0] SC_RETRY  = 9'h02D;
    localparam logic [8:0] SC_SEL1   = 9'h069;
    localparam logic [8:0] SC_SEL2   = 9'h072;
    localparam logic [8:0] SC_SEL3   = 9'h07A;
    localparam logic [8:0] SC_RSHIFT = 9'h059;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_REPEAT
    } rep_state_e;

    // Right shift is deliberately absent: it never produces a command.
    function automatic logic [3:0] sc_to_cmd(input logic [8:0] sc);
        case (sc)
            SC_UP:    sc_to_cmd = CMD_UP;
            SC_LEFT:  sc_to_cmd = CMD_LEFT;
            SC_DOWN:  sc_to_cmd = CMD_DOWN;
            SC_RIGHT: sc_to_cmd = CMD_RIGHT;
            SC_NEXT:  sc_to_cmd = CMD_NEXT;
            SC_BACK:  sc_to_cmd = CMD_BACK;
            SC_RETRY: sc_to_cmd = CMD_RETRY;
            SC_SEL1:  sc_to_cmd = CMD_SEL1;
            SC_SEL2:  sc_to_cmd = CMD_SEL2;
            SC_SEL3:  sc_to_cmd = CMD_SEL3;
            default:  sc_to_cmd = CMD_NONE;
        endcase
    endfunction

    function automatic logic is_dir(input logic [3:0] code);
        is_dir = (code >= CMD_UP) && (code <= CMD_RIGHT);
    endfunction

    function automatic logic [8:0] dir_to_sc(input logic [3:0] code);
        case (code)
            CMD_UP:    dir_to_sc = SC_UP;
            CMD_LEFT:  dir_to_sc = SC_LEFT;
            CMD_DOWN:  dir_to_sc = SC_DOWN;
            CMD_RIGHT: dir_to_sc = SC_RIGHT;
            default:   dir_to_sc = 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO (DEPTH a power of two) with full/empty flags; push and pop may share a cycle.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_rdy && !empty;
        do_push  = push_vld && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/key_cmd_filter.sv
// Turns PS/2 key events into one-shot game commands queued in a 4-deep FIFO; KEY_REPEAT_EN adds held-direction auto-repeat.
// Latency: a press is visible on cmd one cycle after key_valid; repeats every REPEAT_PERIOD after REPEAT_DELAY.
// Backpressure: cmd_valid/cmd_ready; a press into a full FIFO is dropped with an overflow pulse, a repeat only enters an empty FIFO.
module key_cmd_filter
    import game_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic [3:0]   cmd,
    output logic         shift_held,
    output logic         overflow
);
    logic [3:0] press_code;
    logic       press_vld;
    logic       rep_tick;
    logic [3:0] rep_code;
    logic       push_vld;
    logic [3:0] push_dat;
    logic       fifo_full, fifo_empty;
    logic [3:0] head_dat;
    logic       shift_held_q, shift_held_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        press_code = sc_to_cmd(last_change);
        press_vld  = key_valid && key_down[last_change] && (press_code != CMD_NONE);
    end

`ifdef KEY_REPEAT_EN
    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rep_code_q, rep_code_d;
    logic             rep_held;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rep_code_d = rep_code_q;
        rep_tick   = 1'b0;
        rep_held   = key_down[dir_to_sc(rep_code_q)];
        case (state_q)
            REP_DELAY, REP_REPEAT: begin
                if (!rep_held) begin
                    state_d = REP_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == ((state_q == REP_DELAY) ? CNT_W'(REPEAT_DELAY - 1)
                                                              : CNT_W'(REPEAT_PERIOD - 1))) begin
                    rep_tick = 1'b1;
                    state_d  = REP_REPEAT;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A new direction press always restarts the delay from scratch.
        if (press_vld && is_dir(press_code)) begin
            state_d    = REP_DELAY;
            cnt_d      = '0;
            rep_code_d = press_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REP_IDLE;
            cnt_q      <= '0;
            rep_code_q <= CMD_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rep_code_q <= rep_code_d;
        end
    end

    assign rep_code = rep_code_q;
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, CNT_W};
    assign rep_tick       = 1'b0;
    assign rep_code       = CMD_NONE;
`endif

    // Press has priority; a repeat only lands in an empty queue so it never floods.
    always_comb begin
        push_vld     = press_vld || (rep_tick && fifo_empty);
        push_dat     = press_vld ? press_code : rep_code;
        overflow_d   = press_vld && fifo_full && !cmd_ready;
        shift_held_d = key_down[SC_RSHIFT];
    end

    cmd_fifo #(
        .DEPTH (4),
        .W     (4)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (cmd_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_held_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            shift_held_q <= shift_held_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cmd_valid  = !fifo_empty;
    assign cmd        = fifo_empty ? CMD_NONE : head_dat;
    assign shift_held = shift_held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_cmd_filter.sv
// Bench for key_cmd_filter with REPEAT_DELAY=8, REPEAT_PERIOD=4; repeat expectations follow KEY_REPEAT_EN.
module tb_key_cmd_filter;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [3:0]   cmd;
    logic         shift_held;
    logic         overflow;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_head;
    logic       exp_v;

    always #5 clk = ~clk;

    key_cmd_filter #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .shift_held  (shift_held),
        .overflow    (overflow)
    );

    // Scoreboard: every accepted command is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got cmd=%0d but no command expected", cmd);
            end else begin
                exp_head = exp_q.pop_front();
                if (cmd !== exp_head) begin
                    errors++;
                    $display("FAIL sb_cmd got=%0d exp=%0d", cmd, exp_head);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [8:0] sc);
        key_down[sc] = 1'b1;
        last_change  = sc;
        key_valid    = 1'b1;
        step();
        key_valid    = 1'b0;
    endtask

    task automatic release_key(input logic [8:0] sc);
        key_down[sc] = 1'b0;
        last_change  = sc;
        key_valid    = 1'b1;
        step();
        key_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_down = '0; last_change = '0; key_valid = 1'b0; cmd_ready = 1'b0;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd got=%0d exp=0", cmd); end
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL reset_shift got=%0b exp=0", shift_held); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        rst = 1'b0;
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_press_pop();
        cmd_ready = 1'b0;
        exp_q.push_back(4'd1);
        key_down[9'h01D] = 1'b1; last_change = 9'h01D; key_valid = 1'b1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL press_no_comb_path got=%0b exp=0", cmd_valid); end
        step();
        key_valid = 1'b0;
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL press_latency got=%0b exp=1", cmd_valid); end
        checks++; if (cmd !== 4'd1) begin errors++; $display("FAIL press_cmd got=%0d exp=1", cmd); end
        cmd_ready = 1'b1;
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL pop_cmd_zero got=%0d exp=0", cmd); end
        release_key(9'h01D);
    endtask

    task automatic test_repeat();
        cmd_ready = 1'b1;
`ifdef KEY_REPEAT_EN
        repeat (4) exp_q.push_back(4'd2);
`else
        exp_q.push_back(4'd2);
`endif
        press(9'h01C);
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd2) begin errors++; $display("FAIL repeat_press got=%0b/%0d exp=1/2", cmd_valid, cmd); end
        for (int k = 1; k <= 17; k++) begin
            step();
`ifdef KEY_REPEAT_EN
            exp_v = (k == 8) || (k == 12) || (k == 16);
`else
            exp_v = 1'b0;
`endif
            checks++; if (cmd_valid !== exp_v) begin errors++; $display("FAIL repeat_k%0d got=%0b exp=%0b", k, cmd_valid, exp_v); end
        end
        release_key(9'h01C);
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL repeat_after_release_%0d got=%0b exp=0", k, cmd_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] scs [5];
        logic [3:0] codes [5];
        scs   = '{9'h031, 9'h032, 9'h02D, 9'h069, 9'h072};
        codes = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(codes[i]);
            press(scs[i]);
            exp_v = (i == 4);
            checks++; if (overflow !== exp_v) begin errors++; $display("FAIL overflow_press%0d got=%0b exp=%0b", i, overflow, exp_v); end
            checks++; if (cmd !== 4'd5) begin errors++; $display("FAIL full_head%0d got=%0d exp=5", i, cmd); end
        end
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got=%0b exp=0", overflow); end
        release_key(9'h072);
        // Full FIFO with a same-cycle pop must accept the press.
        cmd_ready = 1'b1;
        exp_q.push_back(4'd9);
        press(9'h072);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_overflow got=%0b exp=0", overflow); end
        checks++; if (cmd !== 4'd6) begin errors++; $display("FAIL full_pushpop_head got=%0d exp=6", cmd); end
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", cmd_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
        for (int i = 0; i < 5; i++) key_down[scs[i]] = 1'b0;
        step();
    endtask

    task automatic test_shift();
        cmd_ready = 1'b0;
        key_down[9'h059] = 1'b1; last_change = 9'h059; key_valid = 1'b1;
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL shift_lag got=%0b exp=0", shift_held); end
        step();
        key_valid = 1'b0;
        checks++; if (shift_held !== 1'b1) begin errors++; $display("FAIL shift_held got=%0b exp=1", shift_held); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL shift_no_cmd got=%0b exp=0", cmd_valid); end
        exp_q.push_back(4'd3);
        press(9'h01B);
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd3) begin errors++; $display("FAIL shift_down_cmd got=%0b/%0d exp=1/3", cmd_valid, cmd); end
        release_key(9'h01B);
        key_down[9'h059] = 1'b0;
        step();
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL shift_release got=%0b exp=0", shift_held); end
        cmd_ready = 1'b1;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL shift_drain got=%0b exp=0", cmd_valid); end
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_coincide();
        cmd_ready = 1'b1;
        exp_q.push_back(4'd2);
        press(9'h01C);
        repeat (7) step();
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd4);
        press(9'h023);
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd4) begin errors++; $display("FAIL coincide_cmd got=%0b/%0d exp=1/4", cmd_valid, cmd); end
        for (int k = 9; k <= 16; k++) begin
            step();
            exp_v = (k == 16);
            checks++; if (cmd_valid !== exp_v) begin errors++; $display("FAIL coincide_k%0d got=%0b exp=%0b", k, cmd_valid, exp_v); end
        end
        key_down[9'h01C] = 1'b0;
        key_down[9'h023] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL coincide_release_%0d got=%0b exp=0", k, cmd_valid); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        cmd_ready = 1'b0;
        key_down[9'h059] = 1'b1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        press(9'h01D);
        press(9'h031);
        press(9'h032);
        checks++; if (cmd_valid !== 1'b1 || shift_held !== 1'b1) begin errors++; $display("FAIL pre_reset got=%0b/%0b exp=1/1", cmd_valid, shift_held); end
        rst = 1'b1;
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL mid_reset_cmd got=%0d exp=0", cmd); end
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL mid_reset_shift got=%0b exp=0", shift_held); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow got=%0b exp=0", overflow); end
        exp_q.delete();
        rst = 1'b0;
        cmd_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL held_after_reset_%0d got=%0b exp=0", k, cmd_valid); end
        end
        key_down = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_press_pop();
        test_repeat();
        test_back_to_back();
        test_shift();
`ifdef KEY_REPEAT_EN
        test_coincide();
`endif
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
